prioq_sorted: RTL and testbench

Parametrised priority queue that replaces the fixed 5-entry, 4-bit queue.
- Entries are kept permanently sorted by priority in a register array, using shift-insertion on enqueue.
- The highest-priority entry is always visible at the output, so dequeue costs one cycle with no O(n) search.
- Equal priorities leave in arrival order (FIFO).
- Sits between request producers and a single consumer (scheduler, arbiter).

---
 rtl/prioq_pkg.sv | 20 ++
 rtl/prioq_sorted_if.sv | 35 +++
 rtl/prioq_cell.sv | 31 +++
 rtl/prioq_sorted.sv | 106 ++++++++++
 tb/tb_prioq_sorted.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/prioq_pkg.sv
// Shared defaults, entry layout and width helper for the sorted priority queue.
package prioq_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_PRIO_W = 2;
  localparam int unsigned DEF_DEPTH  = 5;

  typedef struct packed {
    logic [DEF_PRIO_W-1:0] prio;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/prioq_sorted_if.sv
// Producer/consumer bundle of the sorted priority queue.
interface prioq_sorted_if
  import prioq_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PRIO_W = DEF_PRIO_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) ();

  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  logic              enq;
  logic [DATA_W-1:0] in_data;
  logic [PRIO_W-1:0] in_prio;
  logic              deq;
  logic [DATA_W-1:0] out_data;
  logic [PRIO_W-1:0] out_prio;
  logic              out_valid;
  logic              isfull;
  logic              isempty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output enq, in_data, in_prio, deq,
    input  out_data, out_prio, out_valid, isfull, isempty, count, overflow, underflow
  );

  modport slave (
    input  enq, in_data, in_prio, deq,
    output out_data, out_prio, out_valid, isfull, isempty, count, overflow, underflow
  );

endinterface

// File: rtl/prioq_cell.sv
// One storage slot: holds, loads the new entry, or takes a neighbour's entry.
module prioq_cell #(
  parameter int unsigned EW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [EW-1:0] left,
  input  logic [EW-1:0] right,
  input  logic [EW-1:0] new_entry,
  input  logic          hold,
  input  logic          shift_up,
  input  logic          shift_down,
  input  logic          load_new,
  output logic [EW-1:0] slot
);

  logic [EW-1:0] nxt;

  always_comb begin
    nxt = slot;
    if (load_new)        nxt = new_entry;
    else if (shift_up)   nxt = left;
    else if (shift_down) nxt = right;
  end

  always_ff @(posedge clk) begin
    if (rst)        slot <= '0;
    else if (!hold) slot <= nxt;
  end

endmodule

// File: rtl/prioq_sorted.sv
// Priority queue kept sorted by shift-insertion; the head is always slot 0.
module prioq_sorted
  import prioq_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PRIO_W = DEF_PRIO_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input logic           clk,
  input logic           rst,
  prioq_sorted_if.slave q
);

  localparam int unsigned CNT_W = clog2(DEPTH + 1);
  localparam int unsigned EW    = PRIO_W + DATA_W;

  typedef struct packed {
    logic [PRIO_W-1:0] prio;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t             slot [DEPTH];
  ent_t             new_e;
  logic [DEPTH-1:0] ge;
  logic             pop, push;
  logic [CNT_W-1:0] cnt, cnt_eff, cnt_nxt;
  logic             full_q, empty_q, valid_q, ovf_q, unf_q;

  // Pop first, then insert into the popped view; a dropped enq only when full without deq.
  always_comb begin
    pop     = q.deq && !empty_q;
    push    = q.enq && (!full_q || pop);
    cnt_eff = cnt - CNT_W'(pop);
    cnt_nxt = cnt_eff + CNT_W'(push);
    new_e   = '{prio: q.in_prio, data: q.in_data};
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    ent_t left, right, eff;
    logic ge_prev, ld, up, dn, hd;

    if (gi == 0) begin : g_first
      assign left    = '0;
      assign ge_prev = 1'b0;
    end else begin : g_inner
      assign left    = slot[gi-1];
      assign ge_prev = ge[gi-1];
    end

    if (gi == DEPTH - 1) begin : g_last
      assign right = '0;
    end else begin : g_below
      assign right = slot[gi+1];
    end

    // Thermometer code: set at and above the insert position (strict < keeps FIFO among ties).
    assign eff    = pop ? right : slot[gi];
    assign ge[gi] = (CNT_W'(gi) >= cnt_eff) || (eff.prio < q.in_prio);

    assign ld = push && ge[gi] && !ge_prev;
    assign up = push && ge_prev && !pop;
    assign dn = pop && !(push && ge[gi]);
    assign hd = !(ld || up || dn);

    prioq_cell #(.EW(EW)) u_cell (
      .clk        (clk),
      .rst        (rst),
      .left       (left),
      .right      (right),
      .new_entry  (new_e),
      .hold       (hd),
      .shift_up   (up),
      .shift_down (dn),
      .load_new   (ld),
      .slot       (slot[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      full_q  <= (cnt_nxt == CNT_W'(DEPTH));
      empty_q <= (cnt_nxt == '0);
      valid_q <= (cnt_nxt != '0);
      ovf_q   <= q.enq && full_q && !q.deq;
      unf_q   <= q.deq && empty_q;
    end
  end

  assign q.out_data  = slot[0].data;
  assign q.out_prio  = slot[0].prio;
  assign q.out_valid = valid_q;
  assign q.isfull    = full_q;
  assign q.isempty   = empty_q;
  assign q.count     = cnt;
  assign q.overflow  = ovf_q;
  assign q.underflow = unf_q;

endmodule

// File: tb/tb_prioq_sorted.sv
// Directed bench for prioq_sorted with DATA_W=4, PRIO_W=2, DEPTH=4.
module tb_prioq_sorted;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  prioq_sorted_if #(.DATA_W(4), .PRIO_W(2), .DEPTH(4)) bus ();

  prioq_sorted #(.DATA_W(4), .PRIO_W(2), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] p, input logic [3:0] d);
    bus.enq     = 1'b1;
    bus.in_prio = p;
    bus.in_data = d;
    tick();
    bus.enq     = 1'b0;
  endtask

  task automatic pop();
    bus.deq = 1'b1;
    tick();
    bus.deq = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [1:0] p, input logic [3:0] d);
    chk({tag, "_prio"}, 32'(bus.out_prio), 32'(p));
    chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.enq     = 1'b0;
    bus.deq     = 1'b0;
    bus.in_data = '0;
    bus.in_prio = '0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.isempty), 32'd1);
    chk("rst_full", 32'(bus.isfull), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk_head("rst_head", 2'd0, 4'h0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_unf", 32'(bus.underflow), 32'd0);

    // 1: mixed priorities sort to B, D, A, C
    push(2'd1, 4'hA);
    chk_head("t1_first", 2'd1, 4'hA);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    push(2'd3, 4'hB);
    push(2'd0, 4'hC);
    push(2'd2, 4'hD);
    chk("t1_full", 32'(bus.isfull), 32'd1);
    chk("t1_count", 32'(bus.count), 32'd4);
    chk_head("t1_h0", 2'd3, 4'hB);
    pop();
    chk_head("t1_h1", 2'd2, 4'hD);
    chk("t1_count3", 32'(bus.count), 32'd3);
    pop();
    chk_head("t1_h2", 2'd1, 4'hA);
    pop();
    chk_head("t1_h3", 2'd0, 4'hC);
    pop();
    chk("t1_empty", 32'(bus.isempty), 32'd1);
    chk("t1_count0", 32'(bus.count), 32'd0);
    chk_head("t1_cleared", 2'd0, 4'h0);

    // 2: equal priorities leave in arrival order
    push(2'd2, 4'h1);
    push(2'd2, 4'h2);
    push(2'd2, 4'h3);
    chk_head("t2_h0", 2'd2, 4'h1);
    pop();
    chk_head("t2_h1", 2'd2, 4'h2);
    pop();
    chk_head("t2_h2", 2'd2, 4'h3);
    pop();
    chk("t2_empty", 32'(bus.isempty), 32'd1);

    // 3: enq while full is dropped with a one-cycle overflow
    push(2'd1, 4'h1);
    push(2'd1, 4'h2);
    push(2'd1, 4'h3);
    push(2'd1, 4'h4);
    chk("t3_full", 32'(bus.isfull), 32'd1);
    push(2'd3, 4'hF);
    chk("t3_ovf", 32'(bus.overflow), 32'd1);
    chk("t3_count", 32'(bus.count), 32'd4);
    chk_head("t3_head", 2'd1, 4'h1);
    tick();
    chk("t3_ovf_clr", 32'(bus.overflow), 32'd0);

    // 4: enq+deq while full replaces the head without overflow
    bus.deq = 1'b1;
    push(2'd3, 4'hF);
    bus.deq = 1'b0;
    chk("t4_ovf", 32'(bus.overflow), 32'd0);
    chk("t4_count", 32'(bus.count), 32'd4);
    chk_head("t4_head", 2'd3, 4'hF);
    pop();
    chk_head("t4_h1", 2'd1, 4'h2);
    pop();
    chk_head("t4_h2", 2'd1, 4'h3);
    pop();
    chk_head("t4_h3", 2'd1, 4'h4);
    pop();
    chk("t4_empty", 32'(bus.isempty), 32'd1);

    // 5: underflow on empty, and enq+deq on empty accepts the enq
    pop();
    chk("t5_unf", 32'(bus.underflow), 32'd1);
    chk("t5_count", 32'(bus.count), 32'd0);
    bus.deq = 1'b1;
    push(2'd2, 4'h9);
    bus.deq = 1'b0;
    chk("t5_unf2", 32'(bus.underflow), 32'd1);
    chk("t5_count1", 32'(bus.count), 32'd1);
    chk_head("t5_head", 2'd2, 4'h9);
    tick();
    chk("t5_unf_clr", 32'(bus.underflow), 32'd0);
    pop();
    chk("t5_empty", 32'(bus.isempty), 32'd1);

    // 6: reset wins over a simultaneous enq and clears contents
    push(2'd1, 4'h1);
    push(2'd2, 4'h2);
    push(2'd3, 4'h3);
    chk("t6_count3", 32'(bus.count), 32'd3);
    rst = 1'b1;
    push(2'd3, 4'h5);
    rst = 1'b0;
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_empty", 32'(bus.isempty), 32'd1);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk_head("t6_head", 2'd0, 4'h0);
    tick();
    chk("t6_count_hold", 32'(bus.count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
